t_pulse_gen: RTL and testbench

- Upstream stage of t_pulse_latch. Turns a raw, bouncy, asynchronous toggle-request input into clean, fixed-width, clock-synchronous pulses on `t`.
- Pipeline: 2-flop synchroniser, then counter-based debounce FSM, then pulse stretcher.
- One request-level press produces exactly one `t` pulse, so the downstream latch toggles exactly once per press.

---
 rtl/t_pulse_pkg.sv | 14 +
 rtl/t_pulse_gen_sync2.sv | 22 ++
 rtl/t_pulse_gen.sv | 149 ++++++++++++++
 tb/tb_t_pulse_gen.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t_pulse_pkg.sv
// Shared types and widths for the t_pulse_gen debounce/pulse block.
package t_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int DCNT_W = 8;
  localparam int PW_W   = 4;

endpackage

// File: rtl/t_pulse_gen_sync2.sv
// Two-flop synchroniser bringing the asynchronous button input into the clk domain.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second gives it a cycle to settle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/t_pulse_gen.sv
// Debounced toggle-pulse generator feeding t_pulse_latch.
// btn_raw -> sync2 -> debounce FSM -> pulse stretcher -> t, with a wrapping pulse counter.
// Optional auto-repeat while held: define T_PULSE_GEN_AUTO_REPEAT_EN.
module t_pulse_gen
  import t_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_W         = 1,
  parameter int CNT_W           = 8
`ifdef T_PULSE_GEN_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_raw,
  input  logic             en,
  output logic             t,
  output logic             stable,
  output logic [CNT_W-1:0] pulse_cnt
);

  localparam logic [DCNT_W-1:0] DEB_MATCH = DCNT_W'(DEBOUNCE_CYCLES);
  localparam logic [PW_W-1:0]   PW_LOAD   = PW_W'(PULSE_W - 1);

`ifdef T_PULSE_GEN_AUTO_REPEAT_EN
  localparam int RCNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RCNT_W-1:0] REP_MATCH = RCNT_W'(REPEAT_CYCLES - 1);
  logic [RCNT_W-1:0] rcnt;
`endif

  logic              btn_s;
  state_t            state;
  logic [DCNT_W-1:0] dcnt;
  logic [PW_W-1:0]   wcnt;
  logic              fire_req;
  logic              fire;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_s)
  );

  // Fire requests come from an accepted press (and, with auto-repeat, from the repeat tick);
  // they are honoured only when enabled and no pulse is in flight, otherwise dropped.
  always_comb begin
    fire_req = 1'b0;
    if (state == PRESS_WAIT && btn_s && dcnt == DEB_MATCH) begin
      fire_req = 1'b1;
    end
`ifdef T_PULSE_GEN_AUTO_REPEAT_EN
    if (state == HELD && btn_s && rcnt == REP_MATCH) begin
      fire_req = 1'b1;
    end
`endif
    fire = fire_req && en && !t;
  end

  // Debounce FSM: a level change must persist for DEBOUNCE_CYCLES counted samples before it is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      dcnt   <= '0;
      stable <= 1'b0;
`ifdef T_PULSE_GEN_AUTO_REPEAT_EN
      rcnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            dcnt  <= DCNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
            dcnt  <= '0;
          end else if (dcnt == DEB_MATCH) begin
            state  <= HELD;
            stable <= 1'b1;
            dcnt   <= '0;
`ifdef T_PULSE_GEN_AUTO_REPEAT_EN
            rcnt   <= '0;
`endif
          end else begin
            dcnt <= dcnt + DCNT_W'(1);
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            dcnt  <= DCNT_W'(1);
          end
`ifdef T_PULSE_GEN_AUTO_REPEAT_EN
          else if (rcnt == REP_MATCH) begin
            rcnt <= '0;
          end else begin
            rcnt <= rcnt + RCNT_W'(1);
          end
`endif
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= HELD;
            dcnt  <= '0;
          end else if (dcnt == DEB_MATCH) begin
            state  <= IDLE;
            stable <= 1'b0;
            dcnt   <= '0;
`ifdef T_PULSE_GEN_AUTO_REPEAT_EN
            rcnt   <= '0;
`endif
          end else begin
            dcnt <= dcnt + DCNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          dcnt  <= '0;
        end
      endcase
    end
  end

  // Pulse stretcher and counter: hold t for PULSE_W cycles and count each pulse on its first cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t         <= 1'b0;
      wcnt      <= '0;
      pulse_cnt <= '0;
    end else if (fire) begin
      t         <= 1'b1;
      wcnt      <= PW_LOAD;
      pulse_cnt <= pulse_cnt + CNT_W'(1);
    end else if (t) begin
      if (wcnt == '0) begin
        t <= 1'b0;
      end else begin
        wcnt <= wcnt - PW_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_t_pulse_gen.sv
// Self-checking bench for t_pulse_gen: two instances (default and PULSE_W=3/CNT_W=2)
// compared every cycle against a run-length behavioural model, plus directed checks.
module tb_t_pulse_gen;

  localparam int DEB = 4;
  localparam int PW0 = 1;
  localparam int PW1 = 3;
  localparam int REP = 16;

  logic       clk;
  logic       reset;
  logic       btn_raw;
  logic       en;
  logic       t0, stable0;
  logic [7:0] cnt0;
  logic       t1, stable1;
  logic [1:0] cnt1;

  int n_assert = 0;
  int n_fail   = 0;

  t_pulse_gen dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .en        (en),
    .t         (t0),
    .stable    (stable0),
    .pulse_cnt (cnt0)
  );

  t_pulse_gen #(.DEBOUNCE_CYCLES(DEB), .PULSE_W(PW1), .CNT_W(2)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .en        (en),
    .t         (t1),
    .stable    (stable1),
    .pulse_cnt (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: btn is seen two edges late; a level differing from the accepted
  // level for DEB+1 consecutive samples is accepted; acceptance of a press requests a pulse.
  logic       h1, h2;
  logic       ms[2];
  int         mrun[2];
  int         mrem[2];
  int         mhc[2];
  logic [7:0] mcnt[2];

  always @(posedge clk or negedge reset) begin
    logic st_v, req_v;
    int   run_v, rem_v, hc_v;
    if (!reset) begin
      h1 <= 1'b0;
      h2 <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        ms[i]   <= 1'b0;
        mrun[i] <= 0;
        mrem[i] <= 0;
        mhc[i]  <= 0;
        mcnt[i] <= 8'd0;
      end
    end else begin
      h1 <= btn_raw;
      h2 <= h1;
      for (int i = 0; i < 2; i++) begin
        st_v  = ms[i];
        run_v = mrun[i];
        hc_v  = mhc[i];
        req_v = 1'b0;
        if (h2 != st_v) begin
          run_v = run_v + 1;
          if (run_v == DEB + 1) begin
            st_v  = h2;
            run_v = 0;
            hc_v  = 0;
            req_v = h2;
          end
        end else begin
`ifdef T_PULSE_GEN_AUTO_REPEAT_EN
          if (st_v && run_v == 0) begin
            hc_v = hc_v + 1;
            if (hc_v == REP) begin
              req_v = 1'b1;
              hc_v  = 0;
            end
          end
`endif
          run_v = 0;
        end
        rem_v = mrem[i];
        if (req_v && en && rem_v == 0) begin
          rem_v = (i == 0) ? PW0 : PW1;
          mcnt[i] <= mcnt[i] + 8'd1;
        end else if (rem_v > 0) begin
          rem_v = rem_v - 1;
        end
        ms[i]   <= st_v;
        mrun[i] <= run_v;
        mhc[i]  <= hc_v;
        mrem[i] <= rem_v;
      end
    end
  end

  logic [13:0] act_vec, exp_vec;
  assign act_vec = {t0, stable0, cnt0, t1, stable1, cnt1};
  assign exp_vec = {(mrem[0] != 0), ms[0], mcnt[0], (mrem[1] != 0), ms[1], mcnt[1][1:0]};

  // Drive inputs on the falling edge, then let one rising edge happen and settle.
  task automatic cyc(input logic b, input logic e);
    @(negedge clk);
    btn_raw = b;
    en      = e;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset   = 1'b0;
    btn_raw = 1'b0;
    en      = 1'b1;
    @(negedge clk);
    reset   = 1'b1;
  endtask

  task automatic test_reset();
    n_assert++;
    if (act_vec !== 14'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got %h expected %h", act_vec, 14'd0);
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int pulses = 0;
    logic prev = 1'b0;
    logic saw_stable = 1'b0;
    apply_reset();
    for (int k = 0; k < 30; k++) begin
      cyc(k < 10, 1'b1);
      n_assert++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL clean_cycle%0d: got %h expected %h", k, act_vec, exp_vec);
      end
      if (t0 && first < 0) first = k;
      if (t0 && !prev) pulses++;
      prev = t0;
      if (stable0) saw_stable = 1'b1;
    end
    n_assert++;
    if (first !== 2 + DEB) begin
      n_fail++;
      $display("[TB] FAIL clean_latency: got %0d expected %0d", first, 2 + DEB);
    end
    n_assert++;
    if (pulses !== 1) begin
      n_fail++;
      $display("[TB] FAIL clean_pulses: got %0d expected 1", pulses);
    end
    n_assert++;
    if (cnt0 !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL clean_cnt: got %0d expected 1", cnt0);
    end
    n_assert++;
    if (saw_stable !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL clean_stable: got %b expected 1", saw_stable);
    end
  endtask

  task automatic test_bounce();
    logic pat [29];
    int pulses = 0;
    logic prev = 1'b0;
    for (int k = 0; k < 29; k++) pat[k] = (k < 4) ? ((k % 2) == 0) : (k < 14);
    apply_reset();
    for (int k = 0; k < 29; k++) begin
      cyc(pat[k], 1'b1);
      n_assert++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL bounce_cycle%0d: got %h expected %h", k, act_vec, exp_vec);
      end
      if (t0 && !prev) pulses++;
      prev = t0;
    end
    n_assert++;
    if (pulses !== 1 || cnt0 !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL bounce_pulses: got %0d pulses cnt %0d expected 1 and 1", pulses, cnt0);
    end
  endtask

  task automatic test_glitch();
    logic saw = 1'b0;
    apply_reset();
    for (int k = 0; k < 14; k++) begin
      cyc(k < 2, 1'b1);
      n_assert++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL glitch_cycle%0d: got %h expected %h", k, act_vec, exp_vec);
      end
      if (stable0 || t0 || stable1 || t1) saw = 1'b1;
    end
    n_assert++;
    if (saw !== 1'b0 || cnt0 !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL glitch_reject: got activity %b cnt %0d expected 0 and 0", saw, cnt0);
    end
  endtask

  task automatic test_pulse_width();
    int hi3 = 0;
    int rel_hi = 0;
    apply_reset();
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 20; k++) begin
        cyc(k < 10, 1'b1);
        n_assert++;
        if (act_vec !== exp_vec) begin
          n_fail++;
          $display("[TB] FAIL width_p%0d_cycle%0d: got %h expected %h", p, k, act_vec, exp_vec);
        end
        if (t1) hi3++;
        if ((t0 || t1) && k >= 10) rel_hi++;
      end
      if (p == 2) begin
        n_assert++;
        if (hi3 !== 3 * PW1 || cnt1 !== 2'd3) begin
          n_fail++;
          $display("[TB] FAIL width_three: got %0d high cycles cnt %0d expected %0d and 3", hi3, cnt1, 3 * PW1);
        end
      end
    end
    n_assert++;
    if (cnt1 !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL cnt_wrap: got %0d expected 0", cnt1);
    end
    n_assert++;
    if (rel_hi !== 0) begin
      n_fail++;
      $display("[TB] FAIL release_pulse: got %0d high cycles expected 0", rel_hi);
    end
  endtask

  task automatic test_enable();
    logic saw_stable = 1'b0;
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      cyc(k < 10, 1'b0);
      n_assert++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL en_off_cycle%0d: got %h expected %h", k, act_vec, exp_vec);
      end
      if (stable0) saw_stable = 1'b1;
    end
    n_assert++;
    if (saw_stable !== 1'b1 || cnt0 !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL en_off: got stable %b cnt %0d expected 1 and 0", saw_stable, cnt0);
    end
    for (int k = 0; k < 20; k++) begin
      cyc(k < 10, 1'b1);
      n_assert++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL en_on_cycle%0d: got %h expected %h", k, act_vec, exp_vec);
      end
    end
    n_assert++;
    if (cnt0 !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL en_on: got cnt %0d expected 1", cnt0);
    end
  endtask

  task automatic test_reset_mid_pulse();
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1'b1);
      if (t1) break;
    end
    n_assert++;
    if (t1 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_pulse_reach: got t %b expected 1", t1);
    end
    #2;
    reset = 1'b0;
    #1;
    n_assert++;
    if (act_vec !== 14'd0) begin
      n_fail++;
      $display("[TB] FAIL mid_pulse_reset: got %h expected %h", act_vec, 14'd0);
    end
  endtask

  task automatic test_random();
    logic b = 1'b0;
    logic e;
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(3) == 0) b = ~b;
      e = ($urandom_range(7) != 0);
      cyc(b, e);
      n_assert++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL random_cycle%0d: got %h expected %h", k, act_vec, exp_vec);
      end
    end
  endtask

`ifdef T_PULSE_GEN_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    int pulses = 0;
    logic prev = 1'b0;
    apply_reset();
    for (int k = 0; k < 55; k++) begin
      cyc(k < 40, 1'b1);
      n_assert++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL repeat_cycle%0d: got %h expected %h", k, act_vec, exp_vec);
      end
      if (t0 && !prev) pulses++;
      prev = t0;
    end
    n_assert++;
    if (pulses !== 3) begin
      n_fail++;
      $display("[TB] FAIL repeat_pulses: got %0d expected 3", pulses);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    btn_raw = 1'b0;
    en      = 1'b1;
    #2;
    test_reset();
    #10;
    reset = 1'b1;
    test_clean_press();
    test_bounce();
    test_glitch();
    test_pulse_width();
    test_enable();
    test_reset_mid_pulse();
    test_random();
`ifdef T_PULSE_GEN_AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
